// File: rtl/st3_switch_traversal_if.sv
// Channel-side and port-side signal bundle of the switch-traversal stage.
// master = upstream allocator/monitor side, slave = the traversal stage.
interface st3_switch_traversal_if #(
    parameter int FLIT_W = 64,
    parameter int CNT_W  = 16
);
    logic [FLIT_W-1:0] flit_in_0;
    logic [FLIT_W-1:0] flit_in_1;
    logic [FLIT_W-1:0] flit_in_2;
    logic [FLIT_W-1:0] flit_in_3;
    logic [3:0]        valid_in;
    logic [3:0]        apv_0;
    logic [3:0]        apv_1;
    logic [3:0]        apv_2;
    logic [3:0]        apv_3;
    logic [3:0]        ppv_0;
    logic [3:0]        ppv_1;
    logic [3:0]        ppv_2;
    logic [3:0]        ppv_3;
    logic              clear_stats;
    logic [FLIT_W-1:0] flit_out_0;
    logic [FLIT_W-1:0] flit_out_1;
    logic [FLIT_W-1:0] flit_out_2;
    logic [FLIT_W-1:0] flit_out_3;
    logic [3:0]        valid_out;
    logic [CNT_W-1:0]  deflect_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              alloc_err;
    logic [1:0]        err_ch;

    modport master (
        output flit_in_0, flit_in_1, flit_in_2, flit_in_3, valid_in,
        output apv_0, apv_1, apv_2, apv_3, ppv_0, ppv_1, ppv_2, ppv_3, clear_stats,
        input  flit_out_0, flit_out_1, flit_out_2, flit_out_3, valid_out,
        input  deflect_cnt, drop_cnt, alloc_err, err_ch
    );

    modport slave (
        input  flit_in_0, flit_in_1, flit_in_2, flit_in_3, valid_in,
        input  apv_0, apv_1, apv_2, apv_3, ppv_0, ppv_1, ppv_2, ppv_3, clear_stats,
        output flit_out_0, flit_out_1, flit_out_2, flit_out_3, valid_out,
        output deflect_cnt, drop_cnt, alloc_err, err_ch
    );
endinterface

// File: rtl/st3_switch_traversal.sv
// BLESS router switch traversal: 4x4 crossbar driven by allocated port vectors,
// registered output links, allocation protocol checks and saturating statistics.
module st3_switch_traversal #(
    parameter int FLIT_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    st3_switch_traversal_if.slave   sif
);
    logic [FLIT_W-1:0] flit_in [4];
    logic [3:0]        apv     [4];
    logic [3:0]        ppv     [4];

    assign flit_in[0] = sif.flit_in_0;
    assign flit_in[1] = sif.flit_in_1;
    assign flit_in[2] = sif.flit_in_2;
    assign flit_in[3] = sif.flit_in_3;
    assign apv[0] = sif.apv_0;
    assign apv[1] = sif.apv_1;
    assign apv[2] = sif.apv_2;
    assign apv[3] = sif.apv_3;
    assign ppv[0] = sif.ppv_0;
    assign ppv[1] = sif.ppv_1;
    assign ppv[2] = sif.ppv_2;
    assign ppv[3] = sif.ppv_3;

    logic [FLIT_W-1:0] flit_q [4];
    logic [FLIT_W-1:0] flit_d [4];
    logic [3:0]        valid_q, valid_d;
    logic [CNT_W-1:0]  deflect_cnt_q, deflect_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              alloc_err_q, alloc_err_d;
    logic [1:0]        err_ch_q, err_ch_d;

    logic [3:0] win, drop, taken;
    logic [2:0] dfl_inc, drop_inc;
    logic [1:0] first_drop;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Channels are granted in index order; a port already claimed by a
    // lower-index winner turns the later channel into a dropped loser.
    always_comb begin
        taken      = 4'b0;
        win        = 4'b0;
        drop       = 4'b0;
        dfl_inc    = 3'd0;
        drop_inc   = 3'd0;
        first_drop = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (sif.valid_in[c]) begin
                if ($onehot(apv[c]) && ((apv[c] & taken) == 4'b0)) begin
                    win[c] = 1'b1;
                    taken  = taken | apv[c];
                end else begin
                    drop[c] = 1'b1;
                end
            end
        end
        for (int c = 3; c >= 0; c--) begin
            if (win[c] && ((apv[c] & ppv[c]) == 4'b0)) dfl_inc = dfl_inc + 3'd1;
            if (drop[c]) begin
                drop_inc   = drop_inc + 3'd1;
                first_drop = 2'(c);
            end
        end
    end

    // Winners hold distinct ports, so at most one channel matches per port.
    always_comb begin
        valid_d = 4'b0;
        for (int p = 0; p < 4; p++) begin
            flit_d[p] = flit_q[p];
            for (int c = 0; c < 4; c++) begin
                if (win[c] && apv[c][p]) begin
                    valid_d[p] = 1'b1;
                    flit_d[p]  = flit_in[c];
                end
            end
        end
    end

    always_comb begin
        deflect_cnt_d = sat_add(deflect_cnt_q, dfl_inc);
        drop_cnt_d    = sat_add(drop_cnt_q, drop_inc);
        alloc_err_d   = alloc_err_q;
        err_ch_d      = err_ch_q;
        if (!alloc_err_q && (drop != 4'b0)) begin
            alloc_err_d = 1'b1;
            err_ch_d    = first_drop;
        end
        if (sif.clear_stats) begin
            deflect_cnt_d = '0;
            drop_cnt_d    = '0;
            alloc_err_d   = 1'b0;
            err_ch_d      = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= 4'b0;
            deflect_cnt_q <= '0;
            drop_cnt_q    <= '0;
            alloc_err_q   <= 1'b0;
            err_ch_q      <= 2'd0;
            for (int p = 0; p < 4; p++) flit_q[p] <= '0;
        end else begin
            valid_q       <= valid_d;
            deflect_cnt_q <= deflect_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            alloc_err_q   <= alloc_err_d;
            err_ch_q      <= err_ch_d;
            for (int p = 0; p < 4; p++) flit_q[p] <= flit_d[p];
        end
    end

    assign sif.flit_out_0  = flit_q[0];
    assign sif.flit_out_1  = flit_q[1];
    assign sif.flit_out_2  = flit_q[2];
    assign sif.flit_out_3  = flit_q[3];
    assign sif.valid_out   = valid_q;
    assign sif.deflect_cnt = deflect_cnt_q;
    assign sif.drop_cnt    = drop_cnt_q;
    assign sif.alloc_err   = alloc_err_q;
    assign sif.err_ch      = err_ch_q;
endmodule

// File: tb/tb_st3_switch_traversal.sv
// Bench for st3_switch_traversal: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a per-port behavioural model.
module tb_st3_switch_traversal;
    localparam int FLIT_W = 64;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk;
    logic reset_n;

    st3_switch_traversal_if #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) sif ();

    st3_switch_traversal #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (sif)
    );

    logic [FLIT_W-1:0] fin   [4];
    logic [3:0]        apv_t [4];
    logic [3:0]        ppv_t [4];
    logic [3:0]        vin;
    logic              clr;

    assign sif.flit_in_0   = fin[0];
    assign sif.flit_in_1   = fin[1];
    assign sif.flit_in_2   = fin[2];
    assign sif.flit_in_3   = fin[3];
    assign sif.apv_0       = apv_t[0];
    assign sif.apv_1       = apv_t[1];
    assign sif.apv_2       = apv_t[2];
    assign sif.apv_3       = apv_t[3];
    assign sif.ppv_0       = ppv_t[0];
    assign sif.ppv_1       = ppv_t[1];
    assign sif.ppv_2       = ppv_t[2];
    assign sif.ppv_3       = ppv_t[3];
    assign sif.valid_in    = vin;
    assign sif.clear_stats = clr;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each port goes to the lowest-index live channel whose
    // vector is one-hot on that port; every other live channel is dropped.
    logic [FLIT_W-1:0] m_flit [4];
    logic [3:0]        m_valid;
    int                m_dfl, m_drop, m_ch;
    logic              m_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 4; p++) m_flit[p] <= '0;
            m_valid <= 4'b0;
            m_dfl   <= 0;
            m_drop  <= 0;
            m_err   <= 1'b0;
            m_ch    <= 0;
        end else begin
            automatic logic [3:0] won = 4'b0;
            automatic logic [3:0] nv  = 4'b0;
            automatic int n_dfl = 0;
            automatic int n_drop = 0;
            automatic int low = -1;
            for (int p = 0; p < 4; p++) begin
                for (int c = 0; c < 4; c++) begin
                    if (!nv[p] && vin[c] && $countones(apv_t[c]) == 1 && apv_t[c][p]) begin
                        nv[p]  = 1'b1;
                        won[c] = 1'b1;
                        m_flit[p] <= fin[c];
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (won[c] && (apv_t[c] & ppv_t[c]) == 4'b0) n_dfl++;
                if (vin[c] && !won[c]) begin
                    n_drop++;
                    if (low < 0) low = c;
                end
            end
            m_valid <= nv;
            if (clr) begin
                m_dfl  <= 0;
                m_drop <= 0;
                m_err  <= 1'b0;
                m_ch   <= 0;
            end else begin
                m_dfl  <= (m_dfl + n_dfl > MAXC) ? MAXC : m_dfl + n_dfl;
                m_drop <= (m_drop + n_drop > MAXC) ? MAXC : m_drop + n_drop;
                if (!m_err && n_drop > 0) begin
                    m_err <= 1'b1;
                    m_ch  <= low;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid_out",  64'(sif.valid_out),   64'(m_valid));
        chk("flit_out_0", sif.flit_out_0,        m_flit[0]);
        chk("flit_out_1", sif.flit_out_1,        m_flit[1]);
        chk("flit_out_2", sif.flit_out_2,        m_flit[2]);
        chk("flit_out_3", sif.flit_out_3,        m_flit[3]);
        chk("deflect",    64'(sif.deflect_cnt), 64'(m_dfl));
        chk("drop",       64'(sif.drop_cnt),    64'(m_drop));
        chk("alloc_err",  64'(sif.alloc_err),   64'(m_err));
        chk("err_ch",     64'(sif.err_ch),      64'(m_ch));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        vin = 4'b0;
        clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            apv_t[c] = 4'b0;
            ppv_t[c] = 4'b0;
        end
    endtask

    task automatic do_clear();
        set_idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic straight(input logic [FLIT_W-1:0] base);
        vin = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            apv_t[c] = 4'b0001 << c;
            ppv_t[c] = 4'b0001 << c;
            fin[c]   = base + 64'(c);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) fin[c] = '0;
        set_idle();
        #2;
        chk("rst_valid", 64'(sif.valid_out),   64'h0);
        chk("rst_dfl",   64'(sif.deflect_cnt), 64'h0);
        chk("rst_err",   64'(sif.alloc_err),   64'h0);
        #20 reset_n = 1'b1;

        straight(64'hA0);
        tick();
        $display("straight-through: valid_out=%b", sif.valid_out);
        chk("st_valid", 64'(sif.valid_out), 64'hF);
        chk("st_p0", sif.flit_out_0, 64'hA0);
        chk("st_p3", sif.flit_out_3, 64'hA3);
        chk("st_dfl", 64'(sif.deflect_cnt), 64'h0);
        chk("st_drop", 64'(sif.drop_cnt), 64'h0);

        set_idle();
        vin = 4'b0011;
        apv_t[0] = 4'b0100; ppv_t[0] = 4'b0100; fin[0] = 64'hE0;
        apv_t[1] = 4'b0001; ppv_t[1] = 4'b0100; fin[1] = 64'hF1;
        tick();
        $display("deflection: valid_out=%b deflect=%0d", sif.valid_out, sif.deflect_cnt);
        chk("df_valid", 64'(sif.valid_out), 64'h5);
        chk("df_p2", sif.flit_out_2, 64'hE0);
        chk("df_p0", sif.flit_out_0, 64'hF1);
        chk("df_p1_hold", sif.flit_out_1, 64'hA1);
        chk("df_cnt", 64'(sif.deflect_cnt), 64'h1);

        do_clear();
        vin = 4'b0110;
        apv_t[1] = 4'b1000; fin[1] = 64'h61;
        apv_t[2] = 4'b1000; fin[2] = 64'h62;
        tick();
        $display("conflict: valid_out=%b drop=%0d err_ch=%0d", sif.valid_out, sif.drop_cnt, sif.err_ch);
        chk("cf_valid", 64'(sif.valid_out), 64'h8);
        chk("cf_p3", sif.flit_out_3, 64'h61);
        chk("cf_drop", 64'(sif.drop_cnt), 64'h1);
        chk("cf_err", 64'(sif.alloc_err), 64'h1);
        chk("cf_ch", 64'(sif.err_ch), 64'h2);
        set_idle();
        vin = 4'b1000; apv_t[3] = 4'b0011;
        tick();
        $display("later violation ch3: drop=%0d err_ch=%0d", sif.drop_cnt, sif.err_ch);
        chk("cf2_drop", 64'(sif.drop_cnt), 64'h2);
        chk("cf2_ch", 64'(sif.err_ch), 64'h2);

        do_clear();
        vin = 4'b0001; apv_t[0] = 4'b0011;
        tick();
        $display("illegal: valid_out=%b drop=%0d err_ch=%0d", sif.valid_out, sif.drop_cnt, sif.err_ch);
        chk("il_valid", 64'(sif.valid_out), 64'h0);
        chk("il_drop", 64'(sif.drop_cnt), 64'h1);
        chk("il_ch", 64'(sif.err_ch), 64'h0);
        chk("il_err", 64'(sif.alloc_err), 64'h1);
        set_idle();
        for (int c = 0; c < 4; c++) apv_t[c] = 4'b1111;
        tick();
        $display("ignored invalid channel: drop=%0d", sif.drop_cnt);
        chk("iv_drop", 64'(sif.drop_cnt), 64'h1);

        do_clear();
        for (int i = 0; i < 5; i++) begin
            straight(64'h100 + 64'(i * 16));
            for (int c = 0; c < 4; c++) ppv_t[c] = 4'b0001 << ((c + 1) % 4);
            tick();
        end
        $display("saturation: deflect=%0d", sif.deflect_cnt);
        chk("sat_dfl", 64'(sif.deflect_cnt), 64'hF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        $display("clear with deflection: deflect=%0d", sif.deflect_cnt);
        chk("clr_dfl", 64'(sif.deflect_cnt), 64'h0);

        straight(64'hC0);
        ppv_t[0] = 4'b0010;
        tick();
        #2 reset_n = 1'b0;
        #1;
        $display("async reset: valid_out=%b deflect=%0d", sif.valid_out, sif.deflect_cnt);
        chk("ar_valid", 64'(sif.valid_out), 64'h0);
        chk("ar_p0", sif.flit_out_0, 64'h0);
        chk("ar_dfl", 64'(sif.deflect_cnt), 64'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        straight(64'hD0);
        tick();
        $display("resume: valid_out=%b", sif.valid_out);
        chk("rs_valid", 64'(sif.valid_out), 64'hF);
        chk("rs_p2", sif.flit_out_2, 64'hD2);

        for (int i = 0; i < 3000; i++) begin
            vin = 4'($urandom);
            clr = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < 4; c++) begin
                fin[c]   = {$urandom, $urandom};
                apv_t[c] = ($urandom_range(0, 9) < 7) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
                ppv_t[c] = 4'($urandom);
            end
            tick();
        end

        set_idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
